// File: rtl/cam_capture_packer.sv
// Camera capture front-end: selects bytes by pixel mode, crops to a window,
// packs kept bytes into OUT_W-bit words and flags frame/line boundaries.
module cam_capture_packer #(
  parameter int   OUT_W  = 16,
  parameter int   CNT_W  = 12,
  parameter logic VS_POL = 1'b1
) (
  input  logic             cam_pclk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] x_start,
  input  logic [CNT_W-1:0] x_end,
  input  logic [CNT_W-1:0] y_start,
  input  logic [CNT_W-1:0] y_end,
  input  logic             vsync_i,
  input  logic             href_i,
  input  logic [7:0]       din,
  input  logic             fifo_full,
  input  logic             clr_err,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eol,
  output logic             drop_err,
  output logic             frame_active,
  output logic [7:0]       frame_cnt
);

  localparam int               BPW      = OUT_W / 8;
  localparam logic [2:0]       LAST_IDX = 3'(BPW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             vsync_q, vsync_d, href_q, href_d;
  logic [7:0]       din_q;
  logic             phase, sof_pending;
  logic [CNT_W-1:0] col, row;
  logic [2:0]       byte_cnt;
  logic [OUT_W-1:0] pack_buf;

  logic             frame_start, line_end, keep_byte, in_col, in_row, row_active;
  logic             take_byte, word_done, flush, emit;
  logic [OUT_W-1:0] merged, emit_word;

  // vsync_d/href_d are one-cycle-older copies used only for edge detection.
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      vsync_d <= 1'b0;
      href_q  <= 1'b0;
      href_d  <= 1'b0;
      din_q   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      vsync_q <= vsync_i;
      vsync_d <= vsync_q;
      href_q  <= href_i;
      href_d  <= href_q;
      din_q   <= din;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    frame_start = (vsync_q == VS_POL) && (vsync_d != VS_POL);
    line_end    = href_d && !href_q;
    keep_byte   = 1'b0;
    unique case (mode)
      2'd0:    keep_byte = href_q && phase;
      2'd1:    keep_byte = href_q && !phase;
      default: keep_byte = href_q;
    endcase
    in_col     = (col >= x_start) && (col <= x_end);
    in_row     = (row >= y_start) && (row <= y_end);
    row_active = frame_active && in_row;
    take_byte  = keep_byte && row_active && in_col;
    merged     = pack_buf;
    for (int i = 0; i < BPW; i++) begin
      if (byte_cnt == 3'(i)) merged[i*8 +: 8] = din_q;
    end
    word_done = take_byte && (byte_cnt == LAST_IDX);
    flush     = line_end && row_active && (byte_cnt != 3'd0);
    emit      = !frame_start && (word_done || flush);
    emit_word = word_done ? merged : pack_buf;
  end

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_sof      <= 1'b0;
      out_eol      <= 1'b0;
      drop_err     <= 1'b0;
      frame_active <= 1'b0;
      frame_cnt    <= 8'd0;
      sof_pending  <= 1'b0;
      phase        <= 1'b0;
      col          <= '0;
      row          <= '0;
      byte_cnt     <= 3'd0;
      pack_buf     <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      // A drop in the same cycle as clr_err must leave the flag set.
      if (emit && fifo_full) drop_err <= 1'b1;
      else if (clr_err)      drop_err <= 1'b0;

      if (frame_start) begin
        phase        <= 1'b0;
        col          <= '0;
        row          <= '0;
        byte_cnt     <= 3'd0;
        pack_buf     <= '0;
        frame_active <= enable;
        sof_pending  <= enable;
        if (enable) frame_cnt <= frame_cnt + 8'd1;
      end else begin
        phase <= href_q ? !phase : 1'b0;
        if (!href_q)                            col <= '0;
        else if (keep_byte && col != CNT_MAX)   col <= col + CNT_W'(1);
        if (line_end && row != CNT_MAX)         row <= row + CNT_W'(1);

        if (take_byte) begin
          if (word_done) begin
            byte_cnt <= 3'd0;
            pack_buf <= '0;
          end else begin
            byte_cnt <= byte_cnt + 3'd1;
            pack_buf <= merged;
          end
        end

        if (line_end && row_active) begin
          out_eol  <= 1'b1;
          byte_cnt <= 3'd0;
          pack_buf <= '0;
        end

        // A dropped word leaves sof_pending set so the marker moves to the next word.
        if (emit && !fifo_full) begin
          out_valid   <= 1'b1;
          out_data    <= emit_word;
          out_sof     <= sof_pending;
          sof_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_packer.sv
// Bench for cam_capture_packer: three widths (8/16/32) share one stimulus stream and
// are checked every cycle against a line-level packing model plus literal expectations.
module tb_cam_capture_packer;

  typedef struct packed {
    logic        valid;
    logic        sof;
    logic        eol;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  logic        cam_pclk = 1'b0;
  logic        rst, enable, fifo_full, clr_err, vsync_i, href_i;
  logic [1:0]  mode;
  logic [11:0] x_start, x_end, y_start, y_end;
  logic [7:0]  din;

  logic [7:0]  d8;
  logic [15:0] d16;
  logic [31:0] d32;
  logic [2:0]  v, s, e, de, fa;
  logic [7:0]  fc0, fc1, fc2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ev_t exp0[$], exp1[$], exp2[$];
  ev_t log0[$], log1[$], log2[$];

  bit         m_active;
  int         m_row;
  bit [2:0]   sof_pend;
  bit [2:0]   exp_drop;
  int         exp_fcnt;
  logic [7:0] line_q[$];

  always #5 cam_pclk = ~cam_pclk;
  always @(posedge cam_pclk) cyc <= cyc + 1;

  cam_capture_packer #(.OUT_W(8)) u8 (
    .cam_pclk(cam_pclk), .rst(rst), .enable(enable), .mode(mode),
    .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
    .vsync_i(vsync_i), .href_i(href_i), .din(din), .fifo_full(fifo_full), .clr_err(clr_err),
    .out_data(d8), .out_valid(v[0]), .out_sof(s[0]), .out_eol(e[0]), .drop_err(de[0]),
    .frame_active(fa[0]), .frame_cnt(fc0));

  cam_capture_packer #(.OUT_W(16)) u16 (
    .cam_pclk(cam_pclk), .rst(rst), .enable(enable), .mode(mode),
    .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
    .vsync_i(vsync_i), .href_i(href_i), .din(din), .fifo_full(fifo_full), .clr_err(clr_err),
    .out_data(d16), .out_valid(v[1]), .out_sof(s[1]), .out_eol(e[1]), .drop_err(de[1]),
    .frame_active(fa[1]), .frame_cnt(fc1));

  cam_capture_packer #(.OUT_W(32)) u32 (
    .cam_pclk(cam_pclk), .rst(rst), .enable(enable), .mode(mode),
    .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
    .vsync_i(vsync_i), .href_i(href_i), .din(din), .fifo_full(fifo_full), .clr_err(clr_err),
    .out_data(d32), .out_valid(v[2]), .out_sof(s[2]), .out_eol(e[2]), .drop_err(de[2]),
    .frame_active(fa[2]), .frame_cnt(fc2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic void exp_push(input int i, input ev_t ev);
    case (i)
      0:       exp0.push_back(ev);
      1:       exp1.push_back(ev);
      default: exp2.push_back(ev);
    endcase
  endfunction

  function automatic int exp_size(input int i);
    case (i)
      0:       return exp0.size();
      1:       return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  function automatic ev_t exp_pop(input int i);
    ev_t ev;
    ev = '0;
    case (i)
      0:       ev = exp0.pop_front();
      1:       ev = exp1.pop_front();
      default: ev = exp2.pop_front();
    endcase
    return ev;
  endfunction

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    log2.delete();
  endtask

  // Every cycle with a strobe consumes one expected event for that instance.
  task automatic cmp(input int i, input logic ov, input logic os, input logic oe,
                     input logic [31:0] od);
    ev_t got, want;
    got.valid = ov; got.sof = os; got.eol = oe; got.data = od; got.cyc = cyc;
    if (ov || oe) begin
      case (i)
        0:       log0.push_back(got);
        1:       log1.push_back(got);
        default: log2.push_back(got);
      endcase
      if (exp_size(i) == 0) begin
        check($sformatf("u%0d_unexpected_evt", i), {29'd0, ov, os, oe}, 32'd0);
      end else begin
        want = exp_pop(i);
        check($sformatf("u%0d_valid", i), {31'd0, ov}, {31'd0, want.valid});
        check($sformatf("u%0d_sof", i),   {31'd0, os}, {31'd0, want.sof});
        check($sformatf("u%0d_eol", i),   {31'd0, oe}, {31'd0, want.eol});
        if (want.valid) check($sformatf("u%0d_data", i), od, want.data);
      end
    end
  endtask

  always @(negedge cam_pclk) begin
    if (!rst) begin
      cmp(0, v[0], s[0], e[0], {24'd0, d8});
      cmp(1, v[1], s[1], e[1], {16'd0, d16});
      cmp(2, v[2], s[2], e[2], d32);
    end
  end

  task automatic put_eol(input int i);
    ev_t ev;
    ev.valid = 1'b0; ev.sof = 1'b0; ev.eol = 1'b1; ev.data = 32'd0; ev.cyc = 0;
    exp_push(i, ev);
  endtask

  task automatic put_word(input int i, input logic [31:0] w, input bit eol, input bit full);
    ev_t ev;
    if (full) begin
      exp_drop[i] = 1'b1;
      if (eol) put_eol(i);
    end else begin
      ev.valid = 1'b1; ev.sof = sof_pend[i]; ev.eol = eol; ev.data = w; ev.cyc = 0;
      exp_push(i, ev);
      sof_pend[i] = 1'b0;
    end
  endtask

  // Line-level model: select by byte index parity, window by kept-byte column, pack.
  task automatic model_line(input bit full);
    int bpw, n, col;
    logic [31:0] w;
    bit k;
    for (int i = 0; i < 3; i++) begin
      bpw = 1 << i;
      if (m_active && m_row >= int'(y_start) && m_row <= int'(y_end)) begin
        n = 0; w = 32'd0; col = 0;
        for (int j = 0; j < line_q.size(); j++) begin
          k = (mode == 2'd0) ? (j % 2 == 1) : (mode == 2'd1) ? (j % 2 == 0) : 1'b1;
          if (k) begin
            if (col >= int'(x_start) && col <= int'(x_end)) begin
              w[8*n +: 8] = line_q[j];
              n++;
              if (n == bpw) begin
                put_word(i, w, 1'b0, full);
                n = 0;
                w = 32'd0;
              end
            end
            col++;
          end
        end
        if (n > 0) put_word(i, w, 1'b1, full);
        else       put_eol(i);
      end
    end
    m_row++;
  endtask

  task automatic tick();
    @(posedge cam_pclk);
    #1;
  endtask

  task automatic set_line(input logic [7:0] base, input int n);
    line_q.delete();
    for (int j = 0; j < n; j++) line_q.push_back(base + 8'(j));
  endtask

  task automatic send_line(input bit full);
    model_line(full);
    for (int j = 0; j < line_q.size(); j++) begin
      href_i = 1'b1;
      din    = line_q[j];
      tick();
    end
    href_i = 1'b0;
    din    = 8'd0;
    repeat (5) tick();
  endtask

  task automatic start_frame();
    m_active = enable;
    m_row    = 0;
    sof_pend = {3{enable}};
    if (enable) exp_fcnt++;
    vsync_i = 1'b1;
    tick();
    tick();
    vsync_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic full_window();
    x_start = 12'd0; x_end = 12'hFFF;
    y_start = 12'd0; y_end = 12'hFFF;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; fifo_full = 1'b0; clr_err = 1'b0;
    vsync_i = 1'b0; href_i = 1'b0; din = 8'd0; mode = 2'd0;
    full_window();
    m_active = 1'b0; m_row = 0; sof_pend = '0; exp_drop = '0; exp_fcnt = 0;
    repeat (3) tick();
    check("rst_valid",  {29'd0, v},  32'd0);
    check("rst_data16", {16'd0, d16}, 32'd0);
    check("rst_fcnt16", {24'd0, fc1}, 32'd0);
    check("rst_active", {29'd0, fa}, 32'd0);
    check("rst_drop",   {29'd0, de}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Enable low at frame start: raising it mid-frame changes nothing.
    enable = 1'b0;
    start_frame();
    enable = 1'b1;
    mode = 2'd2;
    set_line(8'h20, 4);
    send_line(1'b0);
    check("en0_fcnt16", {24'd0, fc1}, 32'd0);
    check("en0_active", {29'd0, fa}, 32'd0);
    check("en0_nolog16", log1.size(), 32'd0);
    start_frame();
    check("en1_fcnt16", {24'd0, fc1}, 32'd1);
    check("en1_fcnt_model", {24'd0, fc2}, exp_fcnt);
    check("en1_active", {29'd0, fa}, 32'd7);
    clear_logs();
    set_line(8'h24, 4);
    send_line(1'b0);
    check("en1_w0_16", log1[0].data, 32'h2524);
    check("en1_w1_16", log1[1].data, 32'h2726);

    // Mode 0 keeps odd-index bytes; eol follows the last word by one cycle.
    mode = 2'd0;
    start_frame();
    clear_logs();
    set_line(8'h10, 8);
    send_line(1'b0);
    check("m0_w0_16",  log1[0].data, 32'h1311);
    check("m0_sof_16", {31'd0, log1[0].sof}, 32'd1);
    check("m0_w1_16",  log1[1].data, 32'h1715);
    check("m0_eolonly_16", {30'd0, log1[2].valid, log1[2].eol}, 32'd1);
    check("m0_eol_lat", log1[2].cyc - log1[1].cyc, 32'd1);
    check("m0_w0_32",  log2[0].data, 32'h17151311);

    // All-bytes mode with a partial final word.
    mode = 2'd2;
    start_frame();
    clear_logs();
    set_line(8'hA0, 6);
    send_line(1'b0);
    check("pf_w0_32",  log2[0].data, 32'hA3A2A1A0);
    check("pf_w1_32",  log2[1].data, 32'h0000A5A4);
    check("pf_w1_flags32", {29'd0, log2[1].valid, log2[1].sof, log2[1].eol}, 32'b101);
    check("pf_b2b_8",  log0[5].cyc - log0[0].cyc, 32'd5);

    // Window: columns 2..3 of row 1 only.
    x_start = 12'd2; x_end = 12'd3; y_start = 12'd1; y_end = 12'd1;
    start_frame();
    clear_logs();
    for (int l = 0; l < 3; l++) begin
      set_line(8'h30 + 8'(8 * l), 6);
      send_line(1'b0);
    end
    check("win_cnt8",  log0.size(), 32'd3);
    check("win_w0_8",  log0[0].data, 32'h3A);
    check("win_w1_8",  log0[1].data, 32'h3B);
    check("win_eol8",  {31'd0, log0[2].eol}, 32'd1);
    check("win_w0_32", log2[0].data, 32'h00003B3A);
    full_window();

    // Drop: whole first line dropped, sof moves to the next emitted word.
    start_frame();
    clear_logs();
    fifo_full = 1'b1;
    set_line(8'h50, 4);
    send_line(1'b1);
    fifo_full = 1'b0;
    check("drop_flag16", {31'd0, de[1]}, 32'd1);
    check("drop_model",  {29'd0, de}, {29'd0, exp_drop});
    check("drop_novalid16", log1.size(), 32'd1);
    set_line(8'h60, 4);
    send_line(1'b0);
    check("drop_next16", log1[1].data, 32'h6160);
    check("drop_sof16",  {31'd0, log1[1].sof}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_drop = '0;
    tick();
    check("clr_err", {29'd0, de}, 32'd0);

    // Reset after three bytes of a mode-0 line.
    mode = 2'd0;
    start_frame();
    clear_logs();
    put_word(0, 32'h71, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      href_i = 1'b1;
      din    = 8'h70 + 8'(j);
      tick();
    end
    #5;
    rst = 1'b1;
    #1;
    check("rm_valid",  {29'd0, v}, 32'd0);
    check("rm_data16", {16'd0, d16}, 32'd0);
    check("rm_data8",  {24'd0, d8}, 32'd0);
    check("rm_fcnt16", {24'd0, fc1}, 32'd0);
    check("rm_active", {29'd0, fa}, 32'd0);
    href_i = 1'b0;
    din = 8'd0;
    m_active = 1'b0; m_row = 0; sof_pend = '0; exp_drop = '0; exp_fcnt = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rm_pre_w8", log0[0].data, 32'h71);
    clear_logs();
    mode = 2'd2;
    set_line(8'h90, 4);
    send_line(1'b0);
    check("rm_noout16", log1.size(), 32'd0);
    start_frame();
    check("rm_fcnt16", {24'd0, fc1}, 32'd1);
    set_line(8'h80, 4);
    send_line(1'b0);
    check("rm_resume16", log1[0].data, 32'h8180);
    check("rm_resume_sof16", {31'd0, log1[0].sof}, 32'd1);

    repeat (3) tick();
    check("left_exp8",  exp0.size(), 32'd0);
    check("left_exp16", exp1.size(), 32'd0);
    check("left_exp32", exp2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_capture_packer.md
# cam_capture_packer

Parametrised camera capture front-end in the `cam_pclk` domain. It sits between the OV5642 parallel pixel bus and the camera-side write port of the capture FIFO. It selects bytes by pixel mode (Y-only, alternate byte, or all bytes), crops to a programmable window, packs the kept bytes into `OUT_W`-bit words, and marks frame/line boundaries. It generalises the fixed Y-byte toggle write-enable path to multiple modes, configurable word width, windowing, and drop detection.

## Interface
- `OUT_W`, 16, output word width; multiple of 8, range 8..64; `BPW = OUT_W/8` bytes per word.
- `CNT_W`, 12, width of the column and row counters and window bounds.
- `VS_POL`, 1, active level of `vsync_i`; the frame-start event is the transition into this level.
- `cam_pclk`  in  1  pixel clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  capture enable (camera config done); sampled only at frame start.
- `mode`  in  2  0 = keep odd byte index (Y of UYVY); 1 = keep even index; 2 or 3 = keep all bytes.
- `x_start`, `x_end`  in  CNT_W each  inclusive column window, counted in kept bytes.
- `y_start`, `y_end`  in  CNT_W each  inclusive row window, counted in href lines.
- `vsync_i`, `href_i`  in  1 each  camera sync inputs.
- `din`  in  8  camera data.
- `fifo_full`  in  1  downstream FIFO full; the word is dropped when high.
- `clr_err`  in  1  synchronous clear of `drop_err`.
- `out_data`  out  OUT_W  packed word; first kept byte in bits [7:0].
- `out_valid`  out  1  one-cycle write strobe.
- `out_sof`  out  1  high with the first word actually emitted in a frame.
- `out_eol`  out  1  one-cycle end-of-line marker; may occur without `out_valid`.
- `drop_err`  out  1  sticky flag: a word was dropped.
- `frame_active`  out  1  the current frame is being captured.
- `frame_cnt`  out  8  count of captured frames; wraps 255 to 0.

## Operation
- Input stage registers `vsync_i`, `href_i`, and `din` once (`*_q`). All decisions below use these registered values.
- **Frame start:** `vsync_q` enters `VS_POL`. On the following edge:
  - clear row, col, byte phase, and pack buffer;
  - set `frame_active <= enable`;
  - set `sof_pending <= enable`;
  - if `enable` is high, increment `frame_cnt`.
- `enable` changing mid-frame is ignored until the next frame start. No torn frames.
- **Byte phase:** starts at 0 for each line and toggles on every byte with `href_q` high.
  - Mode 0 keeps bytes with phase 1.
  - Mode 1 keeps bytes with phase 0.
  - Modes 2 and 3 keep every byte.
- **Column:** increments on every kept byte, in or out of the window. It saturates at 2^CNT_W-1 and resets at line end.
- **Row:** increments at each href falling edge (line end) and saturates at 2^CNT_W-1.
- **In-window test:** `frame_active` and x_start<=col<=x_end and y_start<=row<=y_end. Only in-window kept bytes enter the pack buffer.
  - If x_start>x_end or y_start>y_end, nothing is captured.
- **Packing:** a byte counter runs 0..BPW-1. When the BPW-th byte arrives, the word is emitted and the counter returns to 0.
- **Line end** (`href_q` 1 to 0) inside the row window while `frame_active`:
  - `out_eol` pulses;
  - if 1..BPW-1 bytes are pending, the partial word is emitted zero-padded in the upper bytes, with `out_valid` high;
  - the counter clears.
  - Line ends outside the row window produce no `out_eol`.
- **Drop:** if `fifo_full` is high at the edge where a word would be emitted:
  - `out_valid` stays 0 and the word is lost;
  - `drop_err` is set;
  - `sof_pending` is kept, so `out_sof` moves to the next emitted word.
  - `clr_err` clears `drop_err`. A set in the same cycle wins over the clear.
- `out_sof` is high only together with `out_valid`, then `sof_pending` clears.
- **Reset (async):** all outputs and internal state go to 0 (`out_data` 0, `frame_cnt` 0, `frame_active` 0). A reset mid-frame discards the frame; capture resumes at the next frame-start event.

## Timing
- Byte sampled on `din` at edge N is registered at N. If it completes a word, `out_valid`/`out_data` are registered at edge N+1, valid for exactly one cycle.
- `href_i` first sampled low at edge M gives `out_eol` and any flush word at edge M+1.
- `vsync_i` sampled active at edge F gives the counter clear and the `frame_active` update at edge F+1.
- Throughput: at most one word per `cam_pclk`. Back-to-back `out_valid` is legal (BPW=1, mode 2).
- Simultaneous line end and word completion on the last byte cannot occur on the same edge; the word emits first, then `out_eol` with `out_valid`=0.

## Test plan
- **Mode 0 packing:** OUT_W=16, mode 0, full window, one line of bytes 0x10..0x17 -> words 0x1311 then 0x1715. The first word has `out_sof`=1. `out_eol` pulses alone one edge after href falls.
- **Partial flush:** mode 2, OUT_W=32, 6-byte line 0xA0..0xA5 -> 0xA3A2A1A0, then 0x0000A5A4 with `out_eol`=1 on the same cycle.
- **Window:** mode 2, OUT_W=8, x 2..3, y 1..1, 3 lines of 6 bytes -> only line 1 bytes at col 2,3 are emitted. Exactly one `out_eol`.
- **Drop path:** `fifo_full`=1 during the first word -> no `out_valid`, `drop_err`=1, `out_sof` appears on the next emitted word. `clr_err` pulse -> `drop_err`=0.
- **Enable timing:** `enable` 0 at frame start then 1 mid-frame -> no output and `frame_cnt` unchanged. The next frame with `enable` 1 -> `frame_cnt` increments 0 to 1 and capture occurs.
- **Reset mid-line:** `rst` asserted after 3 bytes -> all outputs 0 immediately, no flush word. Output resumes only after the next vsync edge.
